// File: rtl/tictactoe_game_logic_if.sv
// Player/board interface for the tic-tac-toe game logic.
//   btn_next / btn_prev / btn_place : level buttons, synchronous to the game clock
//   new_game                        : synchronous, level-sensitive clear of the game
//   block00..block22                : cell codes, row-major (00 empty, 01 X, 10 O)
//   selected                        : cursor cell index 3*row+col (0..8)
//   turn                            : sprite code of the player to move
//   game_over / winner              : end-of-game flag; 00 none, 01 X, 10 O, 11 draw
// master = controller/display side, slave = game logic.
interface tictactoe_game_logic_if;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_place;
  logic       new_game;
  logic [1:0] block00, block01, block02;
  logic [1:0] block10, block11, block12;
  logic [1:0] block20, block21, block22;
  logic [3:0] selected;
  logic [1:0] turn;
  logic       game_over;
  logic [1:0] winner;

  modport master (
    output btn_next, btn_prev, btn_place, new_game,
    input  block00, block01, block02, block10, block11, block12,
           block20, block21, block22, selected, turn, game_over, winner
  );

  modport slave (
    input  btn_next, btn_prev, btn_place, new_game,
    output block00, block01, block02, block10, block11, block12,
           block20, block21, block22, selected, turn, game_over, winner
  );
endinterface

// File: rtl/tictactoe_game_logic.sv
// Tic-tac-toe game logic: cursor movement, mark placement, win/draw detection.
//   CLOCK_50 : system clock, all state updates on its rising edge
//   RESET    : asynchronous active-high reset
//   bus      : tictactoe_game_logic_if.slave (buttons in, board/status out)
// Buttons pass through one input register, then a history register; an event
// is "registered high, history low", so a place press shows on the board two
// clocks after the input rises, and game_over one clock after that.
module tictactoe_game_logic #(
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET,
  tictactoe_game_logic_if.slave        bus
);

  typedef enum logic [1:0] {PLAY, CHECK, WIN, DRAW} state_t;

  localparam int B_NEXT  = 0;
  localparam int B_PREV  = 1;
  localparam int B_PLACE = 2;

  state_t           state_q, state_d;
  logic [8:0][1:0]  board_q, board_d;
  logic [3:0]       sel_q, sel_d;
  logic [1:0]       turn_q, turn_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             arm_q, arm_d;
  logic [2:0]       btn_s_q, btn_s_d;
  logic [2:0]       btn_h_q, btn_h_d;

  logic [2:0]       btn_raw;
  logic [2:0]       evt;
  logic             line_hit;

  function automatic logic has_line(input logic [8:0][1:0] b, input logic [1:0] p);
    return (b[0] == p && b[1] == p && b[2] == p) ||
           (b[3] == p && b[4] == p && b[5] == p) ||
           (b[6] == p && b[7] == p && b[8] == p) ||
           (b[0] == p && b[3] == p && b[6] == p) ||
           (b[1] == p && b[4] == p && b[7] == p) ||
           (b[2] == p && b[5] == p && b[8] == p) ||
           (b[0] == p && b[4] == p && b[8] == p) ||
           (b[2] == p && b[4] == p && b[6] == p);
  endfunction

  assign btn_raw  = {bus.btn_place, bus.btn_prev, bus.btn_next};
  assign evt      = btn_s_q & ~btn_h_q;
  assign line_hit = has_line(board_q, turn_q);

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    sel_d   = sel_q;
    turn_d  = turn_q;
    cnt_d   = cnt_q;
    arm_d   = 1'b1;
    btn_s_d = btn_raw;
    // First cycle after a clear: preload the history with the live level so
    // a button held through reset/new_game needs a release before it counts.
    btn_h_d = arm_q ? btn_s_q : btn_raw;

    case (state_q)
      PLAY: begin
        if (evt[B_PLACE] && board_q[sel_q] == 2'b00) begin
          board_d[sel_q] = turn_q;
          cnt_d          = cnt_q + 4'd1;
          state_d        = CHECK;
        end else if (evt[B_NEXT] ^ evt[B_PREV]) begin
          if (evt[B_NEXT]) sel_d = (sel_q == 4'd8) ? 4'd0 : sel_q + 4'd1;
          else             sel_d = (sel_q == 4'd0) ? 4'd8 : sel_q - 4'd1;
        end
      end
      CHECK: begin
        if (line_hit)            state_d = WIN;
        else if (cnt_q == 4'd9)  state_d = DRAW;
        else begin
          turn_d  = {turn_q[0], turn_q[1]};
          state_d = PLAY;
        end
      end
      default: ;  // WIN and DRAW hold until cleared
    endcase

    if (bus.new_game) begin
      state_d = PLAY;
      board_d = '0;
      sel_d   = 4'd0;
      turn_d  = FIRST_PLAYER;
      cnt_d   = 4'd0;
      arm_d   = 1'b0;
      btn_s_d = 3'b000;
      btn_h_d = 3'b000;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= PLAY;
      board_q <= '0;
      sel_q   <= 4'd0;
      turn_q  <= FIRST_PLAYER;
      cnt_q   <= 4'd0;
      arm_q   <= 1'b0;
      btn_s_q <= 3'b000;
      btn_h_q <= 3'b000;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      sel_q   <= sel_d;
      turn_q  <= turn_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      btn_s_q <= btn_s_d;
      btn_h_q <= btn_h_d;
    end
  end

  assign bus.block00   = board_q[0];
  assign bus.block01   = board_q[1];
  assign bus.block02   = board_q[2];
  assign bus.block10   = board_q[3];
  assign bus.block11   = board_q[4];
  assign bus.block12   = board_q[5];
  assign bus.block20   = board_q[6];
  assign bus.block21   = board_q[7];
  assign bus.block22   = board_q[8];
  assign bus.selected  = sel_q;
  assign bus.turn      = turn_q;
  assign bus.game_over = (state_q == WIN) || (state_q == DRAW);
  assign bus.winner    = (state_q == WIN)  ? turn_q :
                         (state_q == DRAW) ? 2'b11 : 2'b00;

endmodule
